// File: rtl/uart_cmd_parser.sv
// Pops RX bytes, assembles SYNC/CMD/ARG/CHK frames, then pushes ACK/NAK to TX; optional inter-byte timeout.
// Latency: cmd_valid/frame_err one cycle after CHK is latched; wr_uart no earlier than that cycle.
// Backpressure: fetches at most one byte every 2 cycles; stalls in S_RESP while tx_full, leaving RX queued.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         TO_BIT      = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err
);

    typedef enum logic [2:0] {S_SYNC, S_CMD, S_ARG, S_CHK, S_RESP} state_t;

    state_t     state_q, state_d;
    logic       pop_pend_q, pop_pend_d;
    logic       wr_uart_q, wr_uart_d;
    logic [7:0] w_data_q, w_data_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_code_q, cmd_code_d;
    logic [7:0] cmd_arg_q, cmd_arg_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] cmd_r_q, cmd_r_d;
    logic [7:0] arg_r_q, arg_r_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] resp_q, resp_d;
    logic       fetch;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT_CYC - 1);
    logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
`endif

    // pop_pend doubles as the registered pop strobe: r_data is ignored while the pop settles
    assign fetch = (state_q != S_RESP) && !rx_empty && !pop_pend_q;

    always_comb begin
        state_d     = state_q;
        pop_pend_d  = fetch;
        wr_uart_d   = 1'b0;
        w_data_d    = w_data_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        frame_err_d = 1'b0;
        cmd_r_d     = cmd_r_q;
        arg_r_d     = arg_r_q;
        sum_d       = sum_q;
        resp_d      = resp_q;
        case (state_q)
            S_SYNC: if (fetch && r_data == SYNC_BYTE) state_d = S_CMD;
            S_CMD: if (fetch) begin
                cmd_r_d = r_data;
                sum_d   = r_data;
                state_d = S_ARG;
            end
            S_ARG: if (fetch) begin
                arg_r_d = r_data;
                sum_d   = sum_q + r_data;
                state_d = S_CHK;
            end
            S_CHK: if (fetch) begin
                if (r_data == sum_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = cmd_r_q;
                    cmd_arg_d   = arg_r_q;
                    resp_d      = ACK_BYTE;
                end else begin
                    frame_err_d = 1'b1;
                    resp_d      = NAK_BYTE;
                end
                state_d = S_RESP;
            end
            S_RESP: if (!tx_full) begin
                wr_uart_d = 1'b1;
                w_data_d  = resp_q;
                state_d   = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase
`ifdef UART_CMD_TIMEOUT_EN
        to_cnt_d = '0;
        if (state_q inside {S_CMD, S_ARG, S_CHK} && !fetch) begin
            if (to_cnt_q == TO_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_SYNC;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SYNC;
            pop_pend_q  <= 1'b0;
            wr_uart_q   <= 1'b0;
            w_data_q    <= 8'h00;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 8'h00;
            cmd_arg_q   <= 8'h00;
            frame_err_q <= 1'b0;
            cmd_r_q     <= 8'h00;
            arg_r_q     <= 8'h00;
            sum_q       <= 8'h00;
            resp_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            pop_pend_q  <= pop_pend_d;
            wr_uart_q   <= wr_uart_d;
            w_data_q    <= w_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            frame_err_q <= frame_err_d;
            cmd_r_q     <= cmd_r_d;
            arg_r_q     <= arg_r_d;
            sum_q       <= sum_d;
            resp_q      <= resp_d;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`endif

    assign rd_uart   = pop_pend_q;
    assign wr_uart   = wr_uart_q;
    assign w_data    = w_data_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: RX FIFO model, event/TX scoreboards, frame vector table and corner sequences.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYC(100), .TO_BIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg), .frame_err(frame_err)
    );

    typedef struct {
        bit         good;
        logic [7:0] code;
        logic [7:0] arg;
    } evt_t;

    typedef struct {
        int         n;
        logic [7:0] b [6];
        bit         good;
        logic [7:0] code;
        logic [7:0] arg;
    } vec_t;

    logic [7:0] rx_q[$];
    evt_t       exp_evt[$];
    logic [7:0] exp_tx[$];
    vec_t       vecs[6];

    int total = 0;
    int bad = 0;
    int rd_rise = 0, rd_b2b = 0, overlap = 0, cv_cnt = 0, fe_cnt = 0, wr_cnt = 0;
    logic rd_prev = 1'b0;
    logic [7:0] last_code = 8'h00, last_arg = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic set_vec(input int i, input int n, input logic [7:0] b0, b1, b2, b3, b4, b5,
                           input bit good, input logic [7:0] code, arg);
        vecs[i].n = n;
        vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
        vecs[i].b[3] = b3; vecs[i].b[4] = b4; vecs[i].b[5] = b5;
        vecs[i].good = good; vecs[i].code = code; vecs[i].arg = arg;
    endtask

    // Expected outcome of one frame, using the bench's own record of the held code/arg
    task automatic expect_frame(input bit good, input logic [7:0] code, input logic [7:0] arg);
        evt_t e;
        if (good) begin
            last_code = code;
            last_arg  = arg;
        end
        e.good = good; e.code = last_code; e.arg = last_arg;
        exp_evt.push_back(e);
        exp_tx.push_back(good ? 8'h06 : 8'h15);
    endtask

    task automatic push4(input logic [7:0] a, b, c, d);
        rx_q.push_back(a); rx_q.push_back(b); rx_q.push_back(c); rx_q.push_back(d);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && exp_evt.size() == 0 && exp_tx.size() == 0) break;
        end
        if (i == budget) chk({name, " drain timeout"}, 32'd1, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // RX FIFO model plus output monitor; pops on the cycle rd_uart is high
    task automatic monitor();
        logic [7:0] tmp;
        evt_t e;
        forever begin
            @(negedge clk);
            if (rd_uart && rx_q.size() > 0) tmp = rx_q.pop_front();
            rx_empty = (rx_q.size() == 0);
            r_data   = rx_empty ? 8'h00 : rx_q[0];
            if (rd_uart && !rd_prev) rd_rise++;
            if (rd_uart && rd_prev) rd_b2b++;
            if (rd_uart && wr_uart) overlap++;
            rd_prev = rd_uart;
            if (cmd_valid || frame_err) begin
                if (cmd_valid) cv_cnt++;
                if (frame_err) fe_cnt++;
                if (exp_evt.size() == 0) begin
                    chk("unexpected cmd_valid/frame_err", {30'd0, cmd_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_evt.pop_front();
                    chk("evt kind {cmd_valid,frame_err}", {30'd0, cmd_valid, frame_err},
                        e.good ? 32'd2 : 32'd1);
                    chk("evt {cmd_code,cmd_arg}", {16'd0, cmd_code, cmd_arg}, {16'd0, e.code, e.arg});
                end
            end
            if (wr_uart) begin
                wr_cnt++;
                if (exp_tx.size() == 0) chk("unexpected wr_uart", 32'd1, 32'd0);
                else begin
                    tmp = exp_tx.pop_front();
                    chk("w_data", {24'd0, w_data}, {24'd0, tmp});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rd0, cnt, i, j;
        reset_n  = 1'b0;
        tx_full  = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        set_vec(0, 4, 8'hA5, 8'h12, 8'h34, 8'h46, 8'h00, 8'h00, 1'b1, 8'h12, 8'h34);
        set_vec(1, 4, 8'hA5, 8'h12, 8'h34, 8'h47, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        set_vec(2, 6, 8'h00, 8'hFF, 8'hA5, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h01, 8'hFF);
        set_vec(3, 4, 8'hA5, 8'hA5, 8'hA5, 8'h4A, 8'h00, 8'h00, 1'b1, 8'hA5, 8'hA5);
        set_vec(4, 5, 8'h11, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00);
        set_vec(5, 4, 8'hA5, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 8'h80, 8'h80);

        repeat (3) @(negedge clk);
        chk("reset outputs", {5'd0, rd_uart, wr_uart, w_data, cmd_valid, cmd_code, cmd_arg, frame_err},
            32'd0);
        reset_n = 1'b1;
        fork
            monitor();
        join_none

        foreach (vecs[k]) begin
            rd0 = rd_rise;
            for (j = 0; j < vecs[k].n; j++) rx_q.push_back(vecs[k].b[j]);
            expect_frame(vecs[k].good, vecs[k].code, vecs[k].arg);
            wait_idle("vector", 200);
            chk($sformatf("vec%0d rd_uart pulses", k), rd_rise - rd0, vecs[k].n);
            chk($sformatf("vec%0d held code/arg", k), {16'd0, cmd_code, cmd_arg},
                {16'd0, last_code, last_arg});
        end

        // TX backpressure: response stalls, next frame stays queued
        tx_full = 1'b1;
        push4(8'hA5, 8'h12, 8'h34, 8'h46);
        push4(8'hA5, 8'h05, 8'h05, 8'h0A);
        expect_frame(1'b1, 8'h12, 8'h34);
        expect_frame(1'b1, 8'h05, 8'h05);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_valid) break;
        end
        chk("txfull first cmd_valid seen", (i < 100) ? 32'd1 : 32'd0, 32'd1);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd_uart || wr_uart) cnt++;
        end
        chk("txfull stall rd/wr activity", cnt, 0);
        chk("txfull rx bytes still queued", rx_q.size(), 4);
        tx_full = 1'b0;
        wait_idle("txfull", 300);

        // Reset mid-frame after A5 12
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h12);
        for (i = 0; i < 50 && rx_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async reset outputs",
               {5'd0, rd_uart, wr_uart, w_data, cmd_valid, cmd_code, cmd_arg, frame_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        last_code = 8'h00;
        last_arg  = 8'h00;
        i = cv_cnt + fe_cnt;
        j = wr_cnt;
        rx_q.push_back(8'h34);
        rx_q.push_back(8'h46);
        repeat (40) @(negedge clk);
        chk("post-reset bytes drained", rx_q.size(), 0);
        chk("post-reset cmd events", cv_cnt + fe_cnt - i, 0);
        chk("post-reset writes", wr_cnt - j, 0);
        chk("post-reset cmd_code", cmd_code, 0);

`ifdef UART_CMD_TIMEOUT_EN
        j = wr_cnt;
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h12);
        expect_frame(1'b0, 8'h00, 8'h00);
        for (i = 0; i < 300 && exp_evt.size() != 0; i++) @(negedge clk);
        chk("timeout frame_err seen", exp_evt.size(), 0);
        repeat (5) @(negedge clk);
        chk("timeout no write", wr_cnt - j, 0);
        exp_tx.delete();
        push4(8'hA5, 8'h05, 8'h05, 8'h0A);
        expect_frame(1'b1, 8'h05, 8'h05);
        wait_idle("after timeout", 200);
`endif

        chk("rd_uart back-to-back cycles", rd_b2b, 0);
        chk("rd_uart/wr_uart overlap", overlap, 0);
        chk("leftover expectations", exp_evt.size() + exp_tx.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
